// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage.
// Imported by fetch_stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// IF stage: PC, single-outstanding imem fetch, IF/ID register.
// FETCH_PERF_CNT_EN adds fetch/discard performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_discard_cnt
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;

  logic            req_hs;
  logic            rsp_hs;
  logic            load;
  logic            discard;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc = pc_q + XLEN'(PC_STEP);

  assign imem_req_valid = ~rst & (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign imem_rsp_ready = ~rst & (
    (state_q == S_DRAIN) |
    ((state_q == S_WAIT) & (~id_valid_q | id_ready)));

  assign req_hs = imem_req_valid & imem_req_ready;
  assign rsp_hs = imem_rsp_valid & imem_rsp_ready;

  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc4_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q & ~id_ready;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    load       = 1'b0;
    discard    = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (req_hs)
          state_d = redirect_valid ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (rsp_hs) begin
          state_d = S_REQ;
          load    = ~redirect_valid;
          discard = redirect_valid;
        end else if (redirect_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Response still owed from a flushed request
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          discard = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (load) begin
      id_valid_d = 1'b1;
      id_inst_d  = imem_rsp_data;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_inc;
      pc_d       = pc_inc;
    end

    if (redirect_valid) begin
      pc_d       = target;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q  <= INST_NOP;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_discard_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q   <= '0;
      perf_discard_q <= '0;
    end else begin
      if (load)
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (discard)
        perf_discard_q <= perf_discard_q + 32'd1;
    end
  end

  assign perf_fetch_cnt   = perf_fetch_q;
  assign perf_discard_cnt = perf_discard_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

  logic unused_rpc;
  assign unused_rpc = ^redirect_pc[1:0];

endmodule
